// File: rtl/or_job_sequencer_if.sv
// Signal bundle between or_job_sequencer and its job source, result sink and OR datapath.
// master: the sequencer side; slave: the job source / result sink / datapath side.
interface or_job_sequencer_if;
  logic       job_valid;
  logic       job_ready;
  logic [7:0] job_a;
  logic [7:0] job_b;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;

  logic [2:0] write_address;
  logic [7:0] write_data;
  logic       write_en;
  logic       write_rdy;

  logic [2:0] read_address;
  logic       read_en;
  logic [7:0] read_data;
  logic       read_rdy;

  modport master (
    input  job_valid, job_a, job_b,
    output job_ready,
    output res_valid, res_data,
    input  res_ready,
    output write_address, write_data, write_en,
    input  write_rdy,
    output read_address, read_en,
    input  read_data, read_rdy
  );

  modport slave (
    output job_valid, job_a, job_b,
    input  job_ready,
    input  res_valid, res_data,
    output res_ready,
    input  write_address, write_data, write_en,
    output write_rdy,
    input  read_address, read_en,
    output read_data, read_rdy
  );
endinterface

// File: rtl/or_job_sequencer.sv
// Bus master that pushes one A/B operand pair into the OR datapath, pops the Y result and
// returns it on a valid/ready port. Optional poll watchdog: define OR_JOB_SEQUENCER_TIMEOUT_EN.
module or_job_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  or_job_sequencer_if.master        bus,
  output logic                      busy,
  output logic [7:0]                done_count,
  output logic                      timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHK_A  = 3'd1;
  localparam logic [2:0] S_WR_A   = 3'd2;
  localparam logic [2:0] S_CHK_B  = 3'd3;
  localparam logic [2:0] S_WR_B   = 3'd4;
  localparam logic [2:0] S_WAIT_Y = 3'd5;
  localparam logic [2:0] S_POP_Y  = 3'd6;
  localparam logic [2:0] S_OUT    = 3'd7;

  localparam logic [2:0] ADDR_A_FULL_N  = 3'd0;
  localparam logic [2:0] ADDR_B_FULL_N  = 3'd1;
  localparam logic [2:0] ADDR_Y_EMPTY_N = 3'd2;
  localparam logic [2:0] ADDR_Y_DATA    = 3'd3;
  localparam logic [2:0] ADDR_A_PUSH    = 3'd4;
  localparam logic [2:0] ADDR_B_PUSH    = 3'd5;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] res_q;
  logic       accept;
  logic       abandon;

  assign accept = (state == S_IDLE) && bus.job_valid;

  always_comb begin
    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:   if (bus.job_valid)    state_next = S_CHK_A;
      S_CHK_A:  if (bus.read_data[0]) state_next = S_WR_A;
      S_WR_A:   if (bus.write_rdy)    state_next = S_CHK_B;
      S_CHK_B:  if (bus.read_data[0]) state_next = S_WR_B;
      S_WR_B:   if (bus.write_rdy)    state_next = S_WAIT_Y;
      S_WAIT_Y: if (bus.read_data[0]) state_next = S_POP_Y;
      S_POP_Y:  if (bus.read_rdy)     state_next = S_OUT;
      S_OUT:    if (bus.res_ready)    state_next = S_IDLE;
    endcase
    if (abandon) state_next = S_IDLE;
  end

  // Bus outputs decode from the state register alone; status polls keep read_en low
  // because a strobed read of a status address would dequeue the FIFO behind it.
  always_comb begin
    bus.job_ready     = 1'b0;
    bus.res_valid     = 1'b0;
    bus.write_address = 3'd0;
    bus.write_data    = 8'h00;
    bus.write_en      = 1'b0;
    bus.read_address  = 3'd0;
    bus.read_en       = 1'b0;
    case (state)
      S_IDLE:   bus.job_ready = 1'b1;
      S_CHK_A:  bus.read_address = ADDR_A_FULL_N;
      S_WR_A: begin
        bus.write_address = ADDR_A_PUSH;
        bus.write_data    = a_q;
        bus.write_en      = 1'b1;
      end
      S_CHK_B:  bus.read_address = ADDR_B_FULL_N;
      S_WR_B: begin
        bus.write_address = ADDR_B_PUSH;
        bus.write_data    = b_q;
        bus.write_en      = 1'b1;
      end
      S_WAIT_Y: bus.read_address = ADDR_Y_EMPTY_N;
      S_POP_Y: begin
        bus.read_address = ADDR_Y_DATA;
        bus.read_en      = 1'b1;
      end
      S_OUT:    bus.res_valid = 1'b1;
    endcase
  end

  assign bus.res_data = res_q;
  assign busy         = (state != S_IDLE);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      res_q      <= 8'h00;
      done_count <= 8'h00;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q <= bus.job_a;
        b_q <= bus.job_b;
      end
      if ((state == S_POP_Y) && bus.read_rdy) res_q <= bus.read_data;
      if ((state == S_OUT) && bus.res_ready) done_count <= done_count + 8'd1;
    end
  end

`ifdef OR_JOB_SEQUENCER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        poll_state;
  logic        timeout_q;

  assign poll_state = (state == S_CHK_A) || (state == S_CHK_B) || (state == S_WAIT_Y);

  // The TIMEOUT_CYCLES-th poll cycle without progress drops the job; progress wins a tie.
  assign abandon = poll_state && !bus.read_data[0] && (wait_cnt == WAIT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE) wait_cnt <= 16'd0;
      else if (poll_state) wait_cnt <= wait_cnt + 16'd1;
      if (abandon) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign abandon            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_or_job_sequencer.sv
// Directed bench for or_job_sequencer: a vector table for the per-state bus decode plus
// hand-written sequences for backpressure, a full A FIFO, mid-job reset and the watchdog.
module tb_or_job_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       busy;
  logic [7:0] done_count;
  logic       timeout_err;

  or_job_sequencer_if bus ();

  or_job_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .busy        (busy),
    .done_count  (done_count),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

`ifdef OR_JOB_SEQUENCER_TIMEOUT_EN
  localparam int A_FULL_CYCLES = 10;
`else
  localparam int A_FULL_CYCLES = 20;
`endif

  // Datapath model: status bits are bench knobs, Y is the OR of the last pushed A and B.
  logic       a_fn = 1'b1;
  logic       b_fn = 1'b1;
  logic       y_en = 1'b1;
  logic [7:0] a_last = 8'h00;
  logic [7:0] b_last = 8'h00;
  int         wr_cnt  = 0;
  int         pop_cnt = 0;
  int         bad_ren = 0;

  always_comb begin
    bus.read_data = 8'h00;
    case (bus.read_address)
      3'd0: bus.read_data = {7'b0, a_fn};
      3'd1: bus.read_data = {7'b0, b_fn};
      3'd2: bus.read_data = {7'b0, y_en};
      3'd3: bus.read_data = a_last | b_last;
      default: ;
    endcase
  end

  always @(posedge CLK) begin
    if (bus.write_en && bus.write_rdy) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.write_address == 3'd4) a_last <= bus.write_data;
      else if (bus.write_address == 3'd5) b_last <= bus.write_data;
    end
    if (bus.read_en && bus.read_rdy) pop_cnt <= pop_cnt + 1;
    if (bus.read_en && (bus.read_address != 3'd3)) bad_ren <= bad_ren + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // {job_ready, busy, waddr, wdata, wen, raddr, ren, res_valid, res_data, done_count}
  function automatic logic [34:0] ex(input logic jr, input logic bz, input logic [2:0] wa,
                                     input logic [7:0] wd, input logic we, input logic [2:0] ra,
                                     input logic re, input logic rv, input logic [7:0] rd,
                                     input logic [7:0] dn);
    return {jr, bz, wa, wd, we, ra, re, rv, rd, dn};
  endfunction

  function automatic logic [34:0] outs();
    return {bus.job_ready, busy, bus.write_address, bus.write_data, bus.write_en,
            bus.read_address, bus.read_en, bus.res_valid, bus.res_data, done_count};
  endfunction

  typedef struct {
    string       name;
    logic        jv;
    logic [7:0]  ja;
    logic [7:0]  jb;
    logic [5:0]  ctl;   // {write_rdy, a_full_n, b_full_n, y_empty_n, read_rdy, res_ready}
    logic [34:0] exp;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic jv, input logic [7:0] ja,
                              input logic [7:0] jb, input logic [5:0] ctl, input logic [34:0] e);
    vec_t v;
    v.name = nm; v.jv = jv; v.ja = ja; v.jb = jb; v.ctl = ctl; v.exp = e;
    return v;
  endfunction

  task automatic wait_res(input string name, input int limit, output int n);
    n = 0;
    while (!bus.res_valid && (n < limit)) begin
      step();
      n++;
    end
    check({name, "_res_valid"}, 64'(bus.res_valid), 64'd1);
  endtask

  task automatic run_job(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic [7:0] exp_done);
    int n;
    bus.job_valid = 1'b1; bus.job_a = a; bus.job_b = b;
    step();
    bus.job_valid = 1'b0;
    wait_res(name, 50, n);
    check({name, "_res_data"}, 64'(bus.res_data), 64'(exp_res));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check({name, "_done_count"}, 64'(done_count), 64'(exp_done));
  endtask

  vec_t vecs[22];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running, want finished");
    $fatal(1);
  end

  initial begin
    int n;
    int poll;
    int p0;
    logic wen_seen;

    vecs[0]  = mk("idle_accept",  1'b1, 8'h0F, 8'hF0, 6'b111110, ex(1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'h00,8'h00));
    vecs[1]  = mk("chk_a",        1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'h00,8'h00));
    vecs[2]  = mk("wr_a",         1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd4,8'h0F,1'b1,3'd0,1'b0,1'b0,8'h00,8'h00));
    vecs[3]  = mk("chk_b",        1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd1,1'b0,1'b0,8'h00,8'h00));
    vecs[4]  = mk("wr_b",         1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd5,8'hF0,1'b1,3'd0,1'b0,1'b0,8'h00,8'h00));
    vecs[5]  = mk("wait_y",       1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd2,1'b0,1'b0,8'h00,8'h00));
    vecs[6]  = mk("pop_y",        1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd3,1'b1,1'b0,8'h00,8'h00));
    vecs[7]  = mk("out_hold",     1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd0,1'b0,1'b1,8'hFF,8'h00));
    vecs[8]  = mk("out_take",     1'b0, 8'h00, 8'h00, 6'b111111, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd0,1'b0,1'b1,8'hFF,8'h00));
    vecs[9]  = mk("idle_b2b",     1'b1, 8'h3C, 8'h41, 6'b111110, ex(1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'hFF,8'h01));
    vecs[10] = mk("chk_a_full",   1'b0, 8'h00, 8'h00, 6'b101110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'hFF,8'h01));
    vecs[11] = mk("chk_a_free",   1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'hFF,8'h01));
    vecs[12] = mk("wr_a_stall",   1'b0, 8'h00, 8'h00, 6'b011110, ex(1'b0,1'b1,3'd4,8'h3C,1'b1,3'd0,1'b0,1'b0,8'hFF,8'h01));
    vecs[13] = mk("wr_a_go",      1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd4,8'h3C,1'b1,3'd0,1'b0,1'b0,8'hFF,8'h01));
    vecs[14] = mk("chk_b_2",      1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd1,1'b0,1'b0,8'hFF,8'h01));
    vecs[15] = mk("wr_b_2",       1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd5,8'h41,1'b1,3'd0,1'b0,1'b0,8'hFF,8'h01));
    vecs[16] = mk("wait_y_empty", 1'b0, 8'h00, 8'h00, 6'b111010, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd2,1'b0,1'b0,8'hFF,8'h01));
    vecs[17] = mk("wait_y_ready", 1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd2,1'b0,1'b0,8'hFF,8'h01));
    vecs[18] = mk("pop_y_stall",  1'b0, 8'h00, 8'h00, 6'b111100, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd3,1'b1,1'b0,8'hFF,8'h01));
    vecs[19] = mk("pop_y_go",     1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd3,1'b1,1'b0,8'hFF,8'h01));
    vecs[20] = mk("out_take_2",   1'b0, 8'h00, 8'h00, 6'b111111, ex(1'b0,1'b1,3'd0,8'h00,1'b0,3'd0,1'b0,1'b1,8'h7D,8'h01));
    vecs[21] = mk("idle_done",    1'b0, 8'h00, 8'h00, 6'b111110, ex(1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'h7D,8'h02));

    RST_N = 1'b0;
    bus.job_valid = 1'b0; bus.job_a = 8'h00; bus.job_b = 8'h00;
    bus.write_rdy = 1'b1; bus.read_rdy = 1'b1; bus.res_ready = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", 64'(outs()), 64'(ex(1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'h00,8'h00)));
    check("reset_timeout_err", 64'(timeout_err), 64'd0);
    RST_N = 1'b1;
    step();
    check("job_ready_after_release", 64'(bus.job_ready), 64'd1);

    // Per-cycle decode: single job, back-to-back job with every kind of stall
    for (int i = 0; i < 22; i++) begin
      bus.job_valid = vecs[i].jv;
      bus.job_a     = vecs[i].ja;
      bus.job_b     = vecs[i].jb;
      {bus.write_rdy, a_fn, b_fn, y_en, bus.read_rdy, bus.res_ready} = vecs[i].ctl;
      check(vecs[i].name, 64'(outs()), 64'(vecs[i].exp));
      step();
    end
    bus.res_ready = 1'b0;
    check("table_pops", 64'(pop_cnt), 64'd2);
    check("table_writes", 64'(wr_cnt), 64'd4);

    // Minimum latency and result backpressure
    bus.job_valid = 1'b1; bus.job_a = 8'hA0; bus.job_b = 8'h05;
    step();
    bus.job_valid = 1'b0;
    wait_res("latency", 20, n);
    check("latency_cycles", 64'(n), 64'd6);
    for (int i = 0; i < 10; i++) begin
      check("backpressure_hold",
            64'({bus.res_valid, bus.res_data, bus.job_ready, bus.write_en, bus.read_en}),
            64'({1'b1, 8'hA5, 3'b000}));
      step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("backpressure_done", 64'({bus.job_ready, done_count}), 64'({1'b1, 8'h03}));

    // A FIFO full for a stretch, then frees up
    a_fn = 1'b0;
    bus.job_valid = 1'b1; bus.job_a = 8'h12; bus.job_b = 8'h34;
    step();
    bus.job_valid = 1'b0;
    wen_seen = 1'b0;
    repeat (A_FULL_CYCLES) begin
      if (bus.write_en) wen_seen = 1'b1;
      step();
    end
    check("a_full_no_write", 64'(wen_seen), 64'd0);
    a_fn = 1'b1;
    step();
    check("a_write_after_free", 64'({bus.write_en, bus.write_address, bus.write_data}),
          64'({1'b1, 3'd4, 8'h12}));
    wait_res("a_full_job", 20, n);
    check("a_full_res_data", 64'(bus.res_data), 64'h36);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("a_full_done", 64'(done_count), 64'd4);
    check("total_pops", 64'(pop_cnt), 64'd4);
    check("total_writes", 64'(wr_cnt), 64'd8);
    check("no_status_pops", 64'(bad_ren), 64'd0);

    // Reset asserted while waiting on Y
    y_en = 1'b0;
    bus.job_valid = 1'b1; bus.job_a = 8'h21; bus.job_b = 8'h42;
    step();
    bus.job_valid = 1'b0;
    n = 0;
    while (!(busy && (bus.read_address == 3'd2)) && (n < 20)) begin
      step();
      n++;
    end
    check("reach_wait_y", 64'(busy && (bus.read_address == 3'd2)), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_outputs", 64'(outs()),
          64'(ex(1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,1'b0,1'b0,8'h00,8'h00)));
    step();
    RST_N = 1'b1;
    y_en = 1'b1;
    run_job("post_reset", 8'h21, 8'h42, 8'h63, 8'h01);

`ifdef OR_JOB_SEQUENCER_TIMEOUT_EN
    // Watchdog: Y never becomes ready
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check("wd_clear_after_reset", 64'(timeout_err), 64'd0);
    y_en = 1'b0;
    p0 = pop_cnt;
    bus.job_valid = 1'b1; bus.job_a = 8'h01; bus.job_b = 8'h02;
    step();
    bus.job_valid = 1'b0;
    poll = 0;
    n = 0;
    while (busy && (n < 100)) begin
      if (!bus.write_en && !bus.read_en && !bus.res_valid) poll++;
      step();
      n++;
    end
    check("wd_back_to_idle", 64'(busy), 64'd0);
    check("wd_poll_cycles", 64'(poll), 64'd16);
    check("wd_timeout_err", 64'(timeout_err), 64'd1);
    check("wd_done_count", 64'(done_count), 64'd0);
    check("wd_no_pop", 64'(pop_cnt - p0), 64'd0);
    y_en = 1'b1;
    run_job("wd_next_job", 8'h01, 8'h02, 8'h03, 8'h01);
    check("wd_err_sticky", 64'(timeout_err), 64'd1);
`else
    p0 = pop_cnt;
    check("timeout_err_tied_low", 64'(timeout_err), 64'd0);
`endif
    check("final_no_status_pops", 64'(bad_ren), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
